// File: rtl/chip8_alu_exec.sv
// CHIP-8 8XYN execute stage: reads Vx/Vy from the register file, computes the
// ALU result and flag, writes them back through port 1 and the VF port, then
// pulses done. Control outputs are registered, so each one reflects the state
// that was current on the previous cycle. The exception is addr1/addr2, which
// are loaded when start is accepted so that they are valid during READ.
module chip8_alu_exec #(
    parameter bit SHIFT_USES_VY   = 1'b0,
    parameter bit LOGIC_RESETS_VF = 1'b0
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] opcode,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [3:0]  addr1,
    output logic [3:0]  addr2,
    input  logic [7:0]  readdata1,
    input  logic [7:0]  readdata2,
    output logic [7:0]  writedata1,
    output logic        WE1,
    output logic        WE2,
    output logic [7:0]  VFwritedata,
    output logic        WEVF
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WB, DONE} state_t;

    state_t      state;
    logic [3:0]  op_n;
    logic [7:0]  opa;
    logic [7:0]  opb;
    logic [7:0]  res;
    logic [7:0]  flag;
    logic        wr_vx;
    logic        wr_vf;
    logic        ill_pend;

    logic        op_legal;
    logic [7:0]  res_c;
    logic [7:0]  flag_c;
    logic        wf_c;
    logic [7:0]  sh_src;
    logic [8:0]  sum9;
    logic [8:0]  diff_ab;
    logic [8:0]  diff_ba;

    // This block never writes through port 2.
    assign WE2 = 1'b0;

    // Decide whether the incoming opcode is a supported 8XYN form.
    always_comb begin
        op_legal = (opcode[15:12] == 4'h8) &&
                   ((opcode[3:0] <= 4'h7) || (opcode[3:0] == 4'hE));
    end

    // ALU: result, flag and VF-write decision from the latched operands.
    // A clear bit 8 in a 9-bit difference means "no borrow".
    always_comb begin
        sh_src  = SHIFT_USES_VY ? opb : opa;
        sum9    = {1'b0, opa} + {1'b0, opb};
        diff_ab = {1'b0, opa} - {1'b0, opb};
        diff_ba = {1'b0, opb} - {1'b0, opa};
        res_c   = opb;
        flag_c  = 8'h00;
        wf_c    = 1'b0;
        case (op_n)
            4'h0: res_c = opb;
            4'h1: begin res_c = opa | opb; wf_c = LOGIC_RESETS_VF; end
            4'h2: begin res_c = opa & opb; wf_c = LOGIC_RESETS_VF; end
            4'h3: begin res_c = opa ^ opb; wf_c = LOGIC_RESETS_VF; end
            4'h4: begin res_c = sum9[7:0];    flag_c = {7'b0, sum9[8]};     wf_c = 1'b1; end
            4'h5: begin res_c = diff_ab[7:0]; flag_c = {7'b0, ~diff_ab[8]}; wf_c = 1'b1; end
            4'h7: begin res_c = diff_ba[7:0]; flag_c = {7'b0, ~diff_ba[8]}; wf_c = 1'b1; end
            4'h6: begin res_c = {1'b0, sh_src[7:1]}; flag_c = {7'b0, sh_src[0]}; wf_c = 1'b1; end
            4'hE: begin res_c = {sh_src[6:0], 1'b0}; flag_c = {7'b0, sh_src[7]}; wf_c = 1'b1; end
            default: begin res_c = opb; flag_c = 8'h00; wf_c = 1'b0; end
        endcase
    end

    // Sequencer and registered outputs.
    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            WE1         <= 1'b0;
            WEVF        <= 1'b0;
            addr1       <= 4'h0;
            addr2       <= 4'h0;
            writedata1  <= 8'h00;
            VFwritedata <= 8'h00;
            op_n        <= 4'h0;
            opa         <= 8'h00;
            opb         <= 8'h00;
            res         <= 8'h00;
            flag        <= 8'h00;
            wr_vx       <= 1'b0;
            wr_vf       <= 1'b0;
            ill_pend    <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            WE1     <= 1'b0;
            WEVF    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_n     <= opcode[3:0];
                        addr1    <= opcode[11:8];
                        addr2    <= opcode[7:4];
                        busy     <= 1'b1;
                        ill_pend <= ~op_legal;
                        state    <= op_legal ? READ : DONE;
                    end
                end
                READ: begin
                    opa   <= readdata1;
                    opb   <= readdata2;
                    state <= EXEC;
                end
                EXEC: begin
                    res   <= res_c;
                    flag  <= flag_c;
                    wr_vx <= 1'b1;
                    wr_vf <= wf_c;
                    state <= WB;
                end
                WB: begin
                    // When X is VF and a flag is written, the flag must win.
                    WE1         <= wr_vx & ~((addr1 == 4'hF) & wr_vf);
                    WEVF        <= wr_vf;
                    writedata1  <= res;
                    VFwritedata <= flag;
                    state       <= DONE;
                end
                DONE: begin
                    done     <= 1'b1;
                    illegal  <= ill_pend;
                    ill_pend <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
